// File: rtl/addition_control_unit.sv
// Control unit for a 4-stage pipelined floating-point adder/subtractor:
// operand/exponent select, alignment shift, effective-op and sign tracking, handshake.
module addition_control_unit #(
  parameter int EXPO_WIDTH  = 8,
  parameter int MENT_WIDTH  = 23,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic                   sign1_in,
  input  logic                   sign2_in,
  input  logic                   op_sub_in,
  input  logic [EXPO_WIDTH:0]    exp_diff_in,
  output logic                   mux1_sel_out,
  output logic                   mux2_sel_out,
  output logic                   mux3_sel_out,
  output logic [SHIFT_WIDTH-1:0] shift_amt_out,
  output logic                   eff_sub_out,
  input  logic                   mant_neg_in,
  output logic [3:0]             stage_en_out,
  output logic [3:0]             stage_valid_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic                   result_sign_out
);

  localparam logic [EXPO_WIDTH:0] SHIFT_MAX = (EXPO_WIDTH+1)'(MENT_WIDTH + 2);

  logic                   sel_s;
  logic [EXPO_WIDTH:0]    mag_s;
  logic [SHIFT_WIDTH-1:0] shift_s;
  logic                   eff_sub_s;
  logic                   prov_sign_s;
  logic                   en0_s, en1_s, en2_s, en3_s;

  logic                   v0_r, v1_r, v2_r, v3_r;
  logic [SHIFT_WIDTH-1:0] shift0_r, shift1_r;
  logic                   eff0_r, eff1_r, eff2_r;
  logic                   sign0_r, sign1_r, sign2_r, sign3_r;

  // Operand select, saturating shift magnitude and provisional sign
  always_comb begin
    sel_s       = ~exp_diff_in[EXPO_WIDTH];
    mag_s       = exp_diff_in;
    shift_s     = SHIFT_WIDTH'(exp_diff_in);
    eff_sub_s   = sign1_in ^ sign2_in ^ op_sub_in;
    prov_sign_s = sign1_in;
    if (sel_s) begin
      mag_s       = exp_diff_in;
      prov_sign_s = sign1_in;
    end else begin
      mag_s       = ~exp_diff_in + {{EXPO_WIDTH{1'b0}}, 1'b1};
      prov_sign_s = sign2_in ^ op_sub_in;
    end
    if (mag_s > SHIFT_MAX) begin
      shift_s = SHIFT_WIDTH'(SHIFT_MAX);
    end else begin
      shift_s = SHIFT_WIDTH'(mag_s);
    end
  end

  // Enable chain: a stage loads when empty or when the stage after it moves
  always_comb begin
    en3_s = ~v3_r | out_ready;
    en2_s = ~v2_r | en3_s;
    en1_s = ~v1_r | en2_s;
    en0_s = ~v0_r | en1_s;
  end

  // Stage 0 register: captures the incoming operation's control
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v0_r     <= 1'b0;
      shift0_r <= {SHIFT_WIDTH{1'b0}};
      eff0_r   <= 1'b0;
      sign0_r  <= 1'b0;
    end else if (en0_s) begin
      v0_r     <= in_valid;
      shift0_r <= shift_s;
      eff0_r   <= eff_sub_s;
      sign0_r  <= prov_sign_s;
    end
  end

  // Stage 1 register: shift amount presented to the aligner
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_r     <= 1'b0;
      shift1_r <= {SHIFT_WIDTH{1'b0}};
      eff1_r   <= 1'b0;
      sign1_r  <= 1'b0;
    end else if (en1_s) begin
      v1_r     <= v0_r;
      shift1_r <= shift0_r;
      eff1_r   <= eff0_r;
      sign1_r  <= sign0_r;
    end
  end

  // Stage 2 register: effective-subtract presented to the mantissa adder
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2_r    <= 1'b0;
      eff2_r  <= 1'b0;
      sign2_r <= 1'b0;
    end else if (en2_s) begin
      v2_r    <= v1_r;
      eff2_r  <= eff1_r;
      sign2_r <= sign1_r;
    end
  end

  // Stage 3 register: final sign, flipped when a real subtraction went negative
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3_r    <= 1'b0;
      sign3_r <= 1'b0;
    end else if (en3_s) begin
      v3_r    <= v2_r;
      sign3_r <= sign2_r ^ (mant_neg_in & eff2_r & v2_r);
    end
  end

  assign mux1_sel_out    = sel_s;
  assign mux2_sel_out    = sel_s;
  assign mux3_sel_out    = sel_s;
  assign shift_amt_out   = shift1_r;
  assign eff_sub_out     = eff2_r;
  assign result_sign_out = sign3_r;
  assign in_ready        = en0_s;
  assign stage_en_out    = {en3_s, en2_s, en1_s, en0_s};
  assign stage_valid_out = {v3_r, v2_r, v1_r, v0_r};
  assign out_valid       = v3_r;

endmodule

// File: tb/tb_addition_control_unit.sv
// Directed self-checking bench for addition_control_unit: select/shift/sign
// vectors, stall with bubble collapse, back-to-back throughput and async reset.
module tb_addition_control_unit;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic       sign1_in;
  logic       sign2_in;
  logic       op_sub_in;
  logic [8:0] exp_diff_in;
  logic       mux1_sel_out;
  logic       mux2_sel_out;
  logic       mux3_sel_out;
  logic [4:0] shift_amt_out;
  logic       eff_sub_out;
  logic       mant_neg_in;
  logic [3:0] stage_en_out;
  logic [3:0] stage_valid_out;
  logic       out_valid;
  logic       out_ready;
  logic       result_sign_out;

  int errors = 0;
  int checks = 0;
  int idx;
  int retired;

  logic [8:0] sd [6] = '{9'h002, 9'h1FE, 9'h000, 9'h1F0, 9'h010, 9'h1FF};
  logic [5:0] s1_t   = 6'b100011;
  logic [5:0] s2_t   = 6'b011000;
  logic [5:0] sub_t  = 6'b110100;
  logic [5:0] sgn_t  = 6'b101001;

  addition_control_unit dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .sign1_in(sign1_in), .sign2_in(sign2_in), .op_sub_in(op_sub_in),
    .exp_diff_in(exp_diff_in), .mux1_sel_out(mux1_sel_out),
    .mux2_sel_out(mux2_sel_out), .mux3_sel_out(mux3_sel_out),
    .shift_amt_out(shift_amt_out), .eff_sub_out(eff_sub_out),
    .mant_neg_in(mant_neg_in), .stage_en_out(stage_en_out),
    .stage_valid_out(stage_valid_out), .out_valid(out_valid),
    .out_ready(out_ready), .result_sign_out(result_sign_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_single(input string tag, input logic [8:0] d, input logic s1,
                            input logic s2, input logic sub, input logic mn,
                            input logic esel, input logic [4:0] esh,
                            input logic eeff, input logic esign);
    exp_diff_in = d; sign1_in = s1; sign2_in = s2; op_sub_in = sub;
    mant_neg_in = mn; in_valid = 1'b1; out_ready = 1'b1;
    #1;
    chk({tag, "_sel"}, {mux1_sel_out, mux2_sel_out, mux3_sel_out}, {esel, esel, esel});
    chk({tag, "_in_ready"}, in_ready, 1'b1);
    tick();
    in_valid = 1'b0;
    chk({tag, "_valid_s0"}, stage_valid_out, 4'b0001);
    tick();
    chk({tag, "_shift"}, shift_amt_out, esh);
    chk({tag, "_valid_s1"}, stage_valid_out, 4'b0010);
    tick();
    chk({tag, "_eff_sub"}, eff_sub_out, eeff);
    chk({tag, "_valid_s2"}, stage_valid_out, 4'b0100);
    tick();
    chk({tag, "_out_valid"}, out_valid, 1'b1);
    chk({tag, "_sign"}, result_sign_out, esign);
    tick();
    chk({tag, "_drained"}, out_valid, 1'b0);
    mant_neg_in = 1'b0;
  endtask

  initial begin
    rst_n = 1'b1; in_valid = 1'b0; sign1_in = 1'b0; sign2_in = 1'b0;
    op_sub_in = 1'b0; exp_diff_in = 9'h000; mant_neg_in = 1'b0; out_ready = 1'b1;
    #3 rst_n = 1'b0;
    #1;
    chk("rst_valid", stage_valid_out, 4'b0000);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_shift", shift_amt_out, 5'd0);
    chk("rst_eff_sub", eff_sub_out, 1'b0);
    chk("rst_sign", result_sign_out, 1'b0);
    tick();
    tick();
    rst_n = 1'b1;

    // Single operations: tag, diff, s1, s2, sub, mant_neg, sel, shift, eff_sub, sign
    run_single("add_gt",   9'h005, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5,  1'b0, 1'b0);
    run_single("sub_lt",   9'h1FB, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 5'd5,  1'b1, 1'b1);
    run_single("sat",      9'h0FD, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 5'd25, 1'b0, 1'b0);
    run_single("eq_neg",   9'h000, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  1'b1, 1'b1);
    run_single("eq_noeff", 9'h000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 5'd0,  1'b0, 1'b1);
    run_single("lt_neg",   9'h1F0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 5'd16, 1'b1, 1'b0);

    // Stream of six ops, bubble in cycle 2, output stalled for cycles 3..7
    idx = 0;
    retired = 0;
    for (int c = 0; c < 17; c++) begin
      out_ready = (c < 3 || c > 7);
      if (c != 2 && idx < 6) begin
        in_valid = 1'b1; exp_diff_in = sd[idx]; sign1_in = s1_t[idx];
        sign2_in = s2_t[idx]; op_sub_in = sub_t[idx];
      end else begin
        in_valid = 1'b0;
      end
      #1;
      chk("stream_in_ready", in_ready, !(c >= 5 && c <= 7));
      chk("stream_out_valid", out_valid, (c >= 4 && c <= 13));
      if (c == 5) chk("stream_full", stage_valid_out, 4'b1111);
      if (out_valid && out_ready) begin
        if (retired < 6) begin
          chk("stream_sign", result_sign_out, sgn_t[retired]);
        end else begin
          chk("stream_extra_result", retired, 6);
        end
        retired++;
      end
      if (in_valid && in_ready) idx++;
      tick();
    end
    chk("stream_retired", retired, 6);
    chk("stream_accepted", idx, 6);

    // Back-to-back: eight ops with out_ready held high
    out_ready = 1'b1;
    for (int c = 0; c < 14; c++) begin
      logic [31:0] cv;
      cv = c;
      in_valid = (c < 8);
      exp_diff_in = 9'(c); sign1_in = cv[0]; sign2_in = 1'b0; op_sub_in = 1'b0;
      #1;
      chk("b2b_in_ready", in_ready, 1'b1);
      chk("b2b_out_valid", out_valid, (c >= 4 && c <= 11));
      if (c >= 2 && c <= 9) chk("b2b_shift", shift_amt_out, cv - 32'd2);
      if (c >= 4 && c <= 11) chk("b2b_sign", result_sign_out, cv[0]);
      tick();
    end
    in_valid = 1'b0;

    // Async reset with three ops in flight
    for (int c = 0; c < 3; c++) begin
      in_valid = 1'b1; exp_diff_in = 9'h007; sign1_in = 1'b0; sign2_in = 1'b1; op_sub_in = 1'b0;
      tick();
    end
    in_valid = 1'b0;
    #2;
    chk("pre_rst_valid", stage_valid_out, 4'b0111);
    chk("pre_rst_eff_sub", eff_sub_out, 1'b1);
    chk("pre_rst_shift", shift_amt_out, 5'd7);
    rst_n = 1'b0;
    #1;
    chk("arst_valid", stage_valid_out, 4'b0000);
    chk("arst_out_valid", out_valid, 1'b0);
    chk("arst_in_ready", in_ready, 1'b1);
    chk("arst_eff_sub", eff_sub_out, 1'b0);
    chk("arst_shift", shift_amt_out, 5'd0);
    tick();
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("post_rst_quiet", {out_valid, stage_valid_out}, 5'b00000);
    end
    run_single("post_rst", 9'h003, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3, 1'b1, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
